fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage with IF/ID pipeline register for the 32-bit pipelined RISC-V core.
//   Owns the program counter and drives the word-addressed instruction memory address.
//   Captures the returned instruction, PC and PC+4 into the IF/ID register consumed by decode.
//   Handles pipeline stall, branch/jump redirect (flush) and misaligned-target trapping.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC value loaded on reset
//   TRAP_VEC   32'h0000_0100  PC loaded when a redirect target is not word-aligned
//   NOP_INSTR  32'h0000_0013  bubble instruction (addi x0,x0,0) inserted on flush/reset
// PORTS
//   clk                input   1   rising-edge clock
//   reset              input   1   synchronous, active-high reset
//   stall_i            input   1   hazard unit: hold PC and IF/ID contents
//   redirect_i         input   1   EX stage: branch taken / jump, flush IF/ID
//   redirect_target_i  input   32  new PC when redirect_i=1
//   imem_instr_i       input   32  instruction word from instruction memory (combinational read)
//   imem_addr_o        output  32  byte address to instruction memory, equals current PC
//   if_id_instr_o      output  32  registered instruction to decode
//   if_id_pc_o         output  32  registered PC of if_id_instr_o
//   if_id_pc4_o        output  32  registered PC+4 of if_id_instr_o
//   if_id_valid_o      output  1   1 = IF/ID holds a real instruction, 0 = bubble
//   misaligned_o       output  1   sticky: a redirect target with [1:0]!=0 was seen
//   fetch_count_o      output  32  count of instructions accepted into IF/ID
// BEHAVIOUR
//   - imem_addr_o = pc (combinational, no latency); instruction returns same cycle.
//   - Reset (sync, highest priority): pc<=RESET_PC; if_id_instr_o<=NOP_INSTR;
//     if_id_pc_o<=0; if_id_pc4_o<=0; if_id_valid_o<=0; misaligned_o<=0; fetch_count_o<=0.
//   - Per-edge priority: reset > redirect > stall > normal advance.
//   - Redirect (redirect_i=1, overrides stall_i):
//       target[1:0]==0: pc<=redirect_target_i.
//       target[1:0]!=0: pc<=TRAP_VEC, misaligned_o<=1 (sticky until reset).
//       IF/ID <= bubble: instr=NOP_INSTR, valid=0, pc/pc4 = 0. fetch_count_o unchanged.
//   - Stall (stall_i=1, redirect_i=0): pc, all IF/ID outputs and fetch_count_o hold.
//   - Advance (both 0): pc<=pc+4; if_id_instr_o<=imem_instr_i; if_id_pc_o<=pc;
//     if_id_pc4_o<=pc+4; if_id_valid_o<=1; fetch_count_o<=fetch_count_o+1.
//   - Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC advances to 32'h0, no flag.
//     fetch_count_o wraps 32'hFFFF_FFFF -> 0 silently.
//   - pc[1:0] always 00 (RESET_PC and TRAP_VEC must be word-aligned).
//   - Latency: instruction at PC P appears on if_id_* one clock after pc==P with no stall/redirect.
//   - Reset mid-stall or mid-redirect: reset wins, all state to reset values that edge.
//   - No X propagation: all outputs defined from first reset edge.
// TESTING
//   1 Reset, then 4 free cycles, imem returns addr-tagged words -> if_id_pc_o 0,4,8,C;
//     valid=1 from 1st edge after reset deassert; fetch_count_o=4.
//   2 Advance to pc=0x10, stall_i=1 for 3 cycles -> imem_addr_o stays 0x10;
//     IF/ID and fetch_count_o frozen; release -> if_id_pc_o=0x10 next edge.
//   3 redirect_i=1, target=0x40 with stall_i=1 same cycle -> pc=0x40, if_id_valid_o=0,
//     if_id_instr_o=0x00000013; next free edge -> if_id_pc_o=0x40, pc4=0x44.
//   4 redirect target=0x42 -> pc=0x100, misaligned_o=1, bubble in IF/ID;
//     misaligned_o stays 1 until reset.
//   5 RESET_PC=0xFFFFFFF8, 3 free cycles -> if_id_pc_o FFFFFFF8, FFFFFFFC, 0;
//     pc4 of FFFFFFFC = 0.
//   6 Assert reset during stall with redirect pending -> all outputs to reset values,
//     pc=RESET_PC next edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage for the 32-bit pipelined RISC-V core.
// Owns the program counter, drives the instruction-memory address and
// captures the fetched instruction with its PC and PC+4 into the IF/ID
// register consumed by decode.
//
// Control semantics: stall_i and redirect_i are level signals sampled on
// every rising edge. Per edge the priority is reset > redirect > stall >
// advance. A redirect always wins over a stall and squashes IF/ID to a
// bubble. A stall freezes the PC, IF/ID and the fetch counter. An instruction
// counts as accepted by IF/ID only on an advance edge.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_target_i,
    input  logic [31:0] imem_instr_i,
    output logic [31:0] imem_addr_o,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc4_o,
    output logic        if_id_valid_o,
    output logic        misaligned_o,
    output logic [31:0] fetch_count_o
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        target_misaligned;

    // pc+4 wraps modulo 2^32 with no flag.
    assign pc_plus4          = pc + 32'd4;
    assign target_misaligned = (redirect_target_i[1:0] != 2'b00);
    assign imem_addr_o       = pc;

    // Program counter and sticky misaligned-target flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_PC;
            misaligned_o <= 1'b0;
        end else if (redirect_i) begin
            if (target_misaligned) begin
                pc           <= TRAP_VEC;
                misaligned_o <= 1'b1;
            end else begin
                pc <= redirect_target_i;
            end
        end else if (!stall_i) begin
            pc <= pc_plus4;
        end
    end

    // IF/ID pipeline register and accepted-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_instr_o <= NOP_INSTR;
            if_id_pc_o    <= 32'd0;
            if_id_pc4_o   <= 32'd0;
            if_id_valid_o <= 1'b0;
            fetch_count_o <= 32'd0;
        end else if (redirect_i) begin
            // Bubble; the counter is untouched because nothing was accepted.
            if_id_instr_o <= NOP_INSTR;
            if_id_pc_o    <= 32'd0;
            if_id_pc4_o   <= 32'd0;
            if_id_valid_o <= 1'b0;
        end else if (!stall_i) begin
            if_id_instr_o <= imem_instr_i;
            if_id_pc_o    <= pc;
            if_id_pc4_o   <= pc_plus4;
            if_id_valid_o <= 1'b1;
            fetch_count_o <= fetch_count_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus randomized control
// traffic checked against a behavioural model of the fetch stage.
module tb_fetch_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] TRAP = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] target = 32'd0;
    logic [31:0] imem_instr, imem_addr, if_instr, if_pc, if_pc4, fcount;
    logic        if_valid, mis;
    logic [31:0] hi_instr, hi_addr, hi_if_instr, hi_pc, hi_pc4, hi_count;
    logic        hi_valid, hi_mis;

    logic [31:0] mem [64];
    int vec_count  = 0;
    int miss_count = 0;

    // behavioural model state
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_cnt;
    logic        m_valid, m_mis;

    always #5 clk = ~clk;

    // instruction memory: a random word per slot, tagged with the address
    always_comb imem_instr = mem[imem_addr[7:2]] ^ imem_addr;
    always_comb hi_instr   = mem[hi_addr[7:2]] ^ hi_addr;

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall_i(stall), .redirect_i(redirect),
        .redirect_target_i(target), .imem_instr_i(imem_instr),
        .imem_addr_o(imem_addr), .if_id_instr_o(if_instr), .if_id_pc_o(if_pc),
        .if_id_pc4_o(if_pc4), .if_id_valid_o(if_valid), .misaligned_o(mis),
        .fetch_count_o(fcount)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_hi (
        .clk(clk), .reset(reset), .stall_i(stall), .redirect_i(redirect),
        .redirect_target_i(target), .imem_instr_i(hi_instr),
        .imem_addr_o(hi_addr), .if_id_instr_o(hi_if_instr), .if_id_pc_o(hi_pc),
        .if_id_pc4_o(hi_pc4), .if_id_valid_o(hi_valid), .misaligned_o(hi_mis),
        .fetch_count_o(hi_count)
    );

    // Apply one cycle of control inputs, advance the model, sample after the edge.
    task automatic drive(input logic r, input logic s, input logic d, input logic [31:0] t);
        logic [31:0] fetched;
        reset = r; stall = s; redirect = d; target = t;
        fetched = mem[m_pc[7:2]] ^ m_pc;
        if (r) begin
            m_pc = 32'd0; m_instr = NOP; m_ipc = 0; m_ipc4 = 0;
            m_valid = 0; m_mis = 0; m_cnt = 0;
        end else if (d) begin
            if (t % 4 == 0) m_pc = t;
            else begin m_pc = TRAP; m_mis = 1; end
            m_instr = NOP; m_ipc = 0; m_ipc4 = 0; m_valid = 0;
        end else if (!s) begin
            m_instr = fetched; m_ipc = m_pc; m_ipc4 = m_pc + 4;
            m_valid = 1; m_cnt = m_cnt + 1; m_pc = m_pc + 4;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        drive(1, 0, 0, 0); drive(1, 1, 1, 32'h40);
        vec_count++; if (imem_addr !== 32'd0) begin miss_count++; $display("FAIL reset_addr got %h exp %h", imem_addr, 32'd0); end
        vec_count++; if (if_instr !== NOP) begin miss_count++; $display("FAIL reset_instr got %h exp %h", if_instr, NOP); end
        vec_count++; if ({if_valid, mis} !== 2'b00) begin miss_count++; $display("FAIL reset_flags got %b exp 00", {if_valid, mis}); end
        vec_count++; if ({if_pc, if_pc4, fcount} !== 96'd0) begin miss_count++; $display("FAIL reset_regs got %h %h %h exp 0", if_pc, if_pc4, fcount); end
    endtask

    task automatic test_advance;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0);
            vec_count++;
            if (if_pc !== 32'(i * 4) || if_pc4 !== 32'(i * 4 + 4) || if_valid !== 1'b1)
            begin miss_count++; $display("FAIL advance_%0d got pc %h pc4 %h v %b exp pc %h", i, if_pc, if_pc4, if_valid, 32'(i * 4)); end
            vec_count++;
            if (if_instr !== (mem[i] ^ 32'(i * 4))) begin miss_count++; $display("FAIL advance_instr_%0d got %h exp %h", i, if_instr, mem[i] ^ 32'(i * 4)); end
        end
        vec_count++; if (fcount !== 32'd4) begin miss_count++; $display("FAIL advance_count got %0d exp 4", fcount); end
    endtask

    task automatic test_stall;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0);
            vec_count++;
            if (imem_addr !== 32'h10 || if_pc !== 32'hC || fcount !== 32'd4 || if_valid !== 1'b1)
            begin miss_count++; $display("FAIL stall_%0d got addr %h pc %h cnt %0d exp 10 c 4", i, imem_addr, if_pc, fcount); end
        end
        drive(0, 0, 0, 0);
        vec_count++; if (if_pc !== 32'h10 || fcount !== 32'd5) begin miss_count++; $display("FAIL stall_release got pc %h cnt %0d exp 10 5", if_pc, fcount); end
    endtask

    task automatic test_redirect;
        drive(0, 1, 1, 32'h40);
        vec_count++; if (imem_addr !== 32'h40) begin miss_count++; $display("FAIL redir_addr got %h exp 40", imem_addr); end
        vec_count++; if (if_valid !== 1'b0 || if_instr !== NOP || if_pc !== 0 || if_pc4 !== 0 || fcount !== 32'd5)
            begin miss_count++; $display("FAIL redir_bubble got v %b i %h pc %h cnt %0d", if_valid, if_instr, if_pc, fcount); end
        drive(0, 0, 0, 0);
        vec_count++; if (if_pc !== 32'h40 || if_pc4 !== 32'h44 || if_valid !== 1'b1) begin miss_count++; $display("FAIL redir_next got pc %h pc4 %h exp 40 44", if_pc, if_pc4); end
    endtask

    task automatic test_misaligned;
        drive(0, 0, 1, 32'h42);
        vec_count++; if (imem_addr !== TRAP || mis !== 1'b1 || if_valid !== 1'b0)
            begin miss_count++; $display("FAIL misalign got addr %h mis %b v %b exp 100 1 0", imem_addr, mis, if_valid); end
        for (int i = 0; i < 3; i++) drive(0, 0, i == 1, 32'h80);
        vec_count++; if (mis !== 1'b1) begin miss_count++; $display("FAIL misalign_sticky got %b exp 1", mis); end
        vec_count++; if (if_pc !== 32'h80) begin miss_count++; $display("FAIL misalign_after got pc %h exp 80", if_pc); end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0;
        drive(1, 0, 0, 0);
        vec_count++; if (hi_addr !== 32'hFFFF_FFF8) begin miss_count++; $display("FAIL wrap_reset got %h exp fffffff8", hi_addr); end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0);
            vec_count++;
            if (hi_pc !== exp_pc[i] || hi_pc4 !== exp_pc[i] + 32'd4)
            begin miss_count++; $display("FAIL wrap_%0d got pc %h pc4 %h exp %h", i, hi_pc, hi_pc4, exp_pc[i]); end
        end
    endtask

    task automatic test_reset_priority;
        drive(0, 0, 0, 0); drive(0, 0, 1, 32'h33); drive(0, 0, 0, 0);
        drive(1, 1, 1, 32'h200);
        vec_count++; if (imem_addr !== 0 || mis !== 0 || if_valid !== 0 || if_instr !== NOP || fcount !== 0 || if_pc !== 0 || if_pc4 !== 0)
            begin miss_count++; $display("FAIL reset_prio got addr %h mis %b v %b i %h cnt %0d", imem_addr, mis, if_valid, if_instr, fcount); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            logic r, s, d;
            logic [31:0] t;
            r = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 99) < 25);
            d = ($urandom_range(0, 99) < 15);
            t = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
            drive(r, s, d, t);
            vec_count++;
            if (imem_addr !== m_pc || if_instr !== m_instr || if_pc !== m_ipc || if_pc4 !== m_ipc4 ||
                if_valid !== m_valid || mis !== m_mis || fcount !== m_cnt)
            begin
                miss_count++;
                $display("FAIL random_%0d got a %h i %h p %h p4 %h v %b m %b c %0d exp a %h i %h p %h p4 %h v %b m %b c %0d",
                         i, imem_addr, if_instr, if_pc, if_pc4, if_valid, mis, fcount,
                         m_pc, m_instr, m_ipc, m_ipc4, m_valid, m_mis, m_cnt);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        m_pc = 0; m_instr = NOP; m_ipc = 0; m_ipc4 = 0; m_valid = 0; m_mis = 0; m_cnt = 0;
        @(negedge clk);
        test_reset;
        test_advance;
        test_stall;
        test_redirect;
        test_misaligned;
        test_reset_priority;
        test_wrap;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
